// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam int DATA_BITS_BASE = 5;

  // Even parity is the XOR of the first nbits data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input logic [3:0] nbits,
                                      input parity_e mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbits) p = p ^ data[i];
    end
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

  function automatic logic parity_en(input parity_e mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-wide valid/ready handshake between the register block and the transmitter.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo a power-of-two depth.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with runtime divisor and frame format, fed from an internal FIFO.
//   state  | meaning
//   IDLE   | line high; pops the next byte and latches its frame config
//   START  | start bit (0) for one bit period
//   DATA   | data bits LSB first, bit_q selects the bit on the line
//   PARITY | even/odd parity bit, skipped when parity is disabled
//   STOP   | one or two stop bits (1), then back to IDLE for one cycle
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_DIV  = 868
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 tx_if,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RESET_DIV >= 2**DIV_W)
  begin : g_param_check
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2 and RESET_DIV fit DIV_W");
  end

  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty, push, pop, bit_end;
  tx_state_e        state_q;
  logic [DIV_W-1:0] div_q, cnt_q;
  logic [7:0]       byte_q;
  logic [2:0]       bit_q, last_q;
  parity_e          par_q;
  logic             stop2_q, tx_q;

  assign tx_if.tx_ready = !fifo_full;
  assign push    = tx_if.tx_valid && !fifo_full;
  assign pop     = (state_q == IDLE) && !fifo_empty;
  assign bit_end = (cnt_q == div_q - DIV_W'(1));
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE) || (fifo_level != '0);

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (tx_if.tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      byte_q  <= '0;
      last_q  <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
    end else if (state_q == IDLE) begin
      tx_q <= 1'b1;
      if (pop) begin
        // Frame config is frozen here so mid-frame input changes only affect later frames.
        state_q <= START;
        tx_q    <= 1'b0;
        cnt_q   <= '0;
        bit_q   <= '0;
        byte_q  <= fifo_dout;
        div_q   <= (baud_div == '0) ? DIV_W'(1) : baud_div;
        last_q  <= 3'(DATA_BITS_BASE - 1) + {1'b0, cfg_data_bits};
        par_q   <= parity_e'(cfg_parity);
        stop2_q <= cfg_stop2;
      end
    end else if (!bit_end) begin
      cnt_q <= cnt_q + DIV_W'(1);
    end else begin
      cnt_q <= '0;
      case (state_q)
        START: begin
          state_q <= DATA;
          bit_q   <= '0;
          tx_q    <= byte_q[0];
        end
        DATA: begin
          if (bit_q == last_q) begin
            bit_q <= '0;
            if (parity_en(par_q)) begin
              state_q <= PARITY;
              tx_q    <= parity_bit(byte_q, {1'b0, last_q} + 4'd1, par_q);
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            bit_q <= bit_q + 3'd1;
            tx_q  <= byte_q[bit_q + 3'd1];
          end
        end
        PARITY: begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        STOP: begin
          tx_q <= 1'b1;
          if (stop2_q && bit_q == 3'd0) begin
            bit_q <= 3'd1;
          end else begin
            state_q <= IDLE;
            bit_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor checks each frame bit by bit.
module tb_uart_tx_fifo;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          div;
    bit          b2b;
  } fr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  cfg_data_bits, cfg_parity;
  logic        cfg_stop2;
  logic        tx, busy;
  logic [2:0]  fifo_level;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  frames_started = 0;
  bit  mute = 1'b0;
  bit  in_frame = 1'b0;
  fr_t sbq[$];

  uart_tx_fifo_if tx_if();

  uart_tx_fifo #(.DIV_W(16), .FIFO_DEPTH(4), .RESET_DIV(868)) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_if         (tx_if),
    .baud_div      (baud_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx            (tx),
    .busy          (busy),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic fr_t from_str(input string s, input int div, input bit b2b);
    fr_t f;
    f.bits = '0;
    f.len  = s.len();
    for (int i = 0; i < s.len(); i++) f.bits[i] = (s.getc(i) == 8'h31);
    f.div = div;
    f.b2b = b2b;
    return f;
  endfunction

  // Frame builder: start, nb data bits LSB first, optional parity (1 even, 2 odd), stop bits.
  function automatic fr_t build(input logic [7:0] d, input int nb, input int par, input bit st2,
                                input int div, input bit b2b);
    fr_t f;
    logic p;
    int k;
    f.bits = '0;
    p = 1'b0;
    k = 1;
    for (int i = 0; i < nb; i++) begin
      f.bits[k] = d[i];
      p = p ^ d[i];
      k++;
    end
    if (par == 1) begin f.bits[k] = p;  k++; end
    if (par == 2) begin f.bits[k] = ~p; k++; end
    f.bits[k] = 1'b1; k++;
    if (st2) begin f.bits[k] = 1'b1; k++; end
    f.len = k;
    f.div = div;
    f.b2b = b2b;
    return f;
  endfunction

  task automatic set_cfg(input int nb, input int par, input bit st2, input int div);
    cfg_data_bits = 2'(nb - 5);
    cfg_parity    = 2'(par);
    cfg_stop2     = st2;
    baud_div      = 16'(div);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge with tx_valid still high.
  task automatic send(input logic [7:0] d, input fr_t e, input bit track);
    bit ok;
    ok = 1'b0;
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    for (int w = 0; w < 100 && !ok; w++) begin
      ok = tx_if.tx_ready;
      @(posedge clk);
      if (ok && track) sbq.push_back(e);
      @(negedge clk);
    end
    chk("send_accept", int'(ok), 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0 && !in_frame) done = 1'b1;
    end
    chk(name, int'(done), 1);
  endtask

  // Line monitor: a falling tx while idle starts a frame, checked against the next queued entry.
  initial begin
    fr_t e;
    int  err, start_c, prev_start, prev_span, span;
    prev_start = 0;
    prev_span  = 0;
    forever begin
      @(negedge clk);
      if (!mute && rst === 1'b1 && tx === 1'b0) begin
        frames_started++;
        if (sbq.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = sbq.pop_front();
          start_c  = cyc;
          in_frame = 1'b1;
          if (e.b2b) chk("frame_gap", start_c - (prev_start + prev_span), 1);
          span = e.len * e.div;
          err  = 0;
          for (int s = 0; s < span; s++) begin
            if (s > 0) @(negedge clk);
            if (tx !== e.bits[s / e.div]) err++;
          end
          chk("frame_bits", err, 0);
          @(negedge clk);
          chk("idle_after_stop", int'(tx), 1);
          prev_start = start_c;
          prev_span  = span;
          in_frame   = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst [6];
    int fs0;
    burst[0] = 8'h3C; burst[1] = 8'h81; burst[2] = 8'h5A;
    burst[3] = 8'h07; burst[4] = 8'hFF; burst[5] = 8'hC6;

    // Reset held with tx_valid high: nothing may be pushed.
    rst = 1'b0;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'hA5;
    set_cfg(8, 0, 0, 4);
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_ready", int'(tx_if.tx_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_level", int'(fifo_level), 0);
    end

    // 8N1 div=4 0xA5 pushed on the first edge after release.
    rst = 1'b1;
    sbq.push_back(from_str("0101001011", 4, 1'b0));
    @(negedge clk);
    chk("push_level", int'(fifo_level), 1);
    chk("push_tx", int'(tx), 1);
    chk("push_busy", int'(busy), 1);
    tx_if.tx_valid = 1'b0;
    @(negedge clk);
    chk("start_tx", int'(tx), 0);
    chk("pop_level", int'(fifo_level), 0);
    repeat (39) @(negedge clk);
    chk("busy_last_cycle", int'(busy), 1);
    @(negedge clk);
    chk("busy_fall", int'(busy), 0);
    wait_idle(200, "idle_8n1");

    // 7E2 div=3 0xD3: bit 7 ignored, parity 0.
    set_cfg(7, 1, 1, 3);
    send(8'hD3, from_str("01100101011", 3, 1'b0), 1'b1);
    tx_if.tx_valid = 1'b0;
    wait_idle(200, "idle_7e2");

    // 5O1 div=0 behaves as div=1.
    set_cfg(5, 2, 0, 0);
    send(8'h1F, from_str("01111101", 1, 1'b0), 1'b1);
    tx_if.tx_valid = 1'b0;
    wait_idle(100, "idle_5o1");

    // Burst of six with a config change while the second frame is on the line.
    set_cfg(8, 0, 0, 2);
    fs0 = frames_started;
    for (int i = 0; i < 6; i++) begin
      if (i < 2) send(burst[i], build(burst[i], 8, 0, 1'b0, 2, i > 0), 1'b1);
      else       send(burst[i], build(burst[i], 6, 2, 1'b1, 3, 1'b1), 1'b1);
      if (i == 4) begin
        chk("full_level", int'(fifo_level), 4);
        chk("full_ready", int'(tx_if.tx_ready), 0);
      end
    end
    chk("refill_level", int'(fifo_level), 4);
    chk("refill_ready", int'(tx_if.tx_ready), 0);
    tx_if.tx_valid = 1'b0;
    for (int i = 0; i < 200 && frames_started < fs0 + 2; i++) @(negedge clk);
    chk("second_frame_started", int'(frames_started >= fs0 + 2), 1);
    repeat (5) @(negedge clk);
    set_cfg(6, 2, 1, 3);
    wait_idle(600, "idle_burst");
    chk("burst_frames", frames_started - fs0, 6);

    // Reset during data bit 3 of 0xA5 with a second byte queued.
    set_cfg(8, 0, 0, 4);
    mute = 1'b1;
    send(8'hA5, build(8'hA5, 8, 0, 1'b0, 4, 1'b0), 1'b0);
    send(8'h77, build(8'h77, 8, 0, 1'b0, 4, 1'b0), 1'b0);
    tx_if.tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("bit3_tx", int'(tx), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", int'(tx), 1);
    chk("abort_level", int'(fifo_level), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(tx_if.tx_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mute = 1'b0;
    chk("discard_busy", int'(busy), 0);
    repeat (6) @(negedge clk);
    chk("discard_tx", int'(tx), 1);
    send(8'h3C, build(8'h3C, 8, 0, 1'b0, 4, 1'b0), 1'b1);
    tx_if.tx_valid = 1'b0;
    wait_idle(200, "idle_after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. Adds:
- runtime baud divisor
- runtime frame format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits
- valid/ready level handshake in place of edge detection
- internal TX FIFO

Sits between the CPU-side peripheral register block and the serial pin.

Parameters:
DIV_W, 16, width of baud_div.
FIFO_DEPTH, 4, entries in the TX FIFO. Power of two, ≥2.
RESET_DIV, 868, informative default divisor for the register block (100 MHz / 115200). Not used inside this block.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (0 = reset), sampled on posedge clk
baud_div  input  DIV_W  clock cycles per bit; 0 treated as 1
cfg_data_bits  input  2  data bits = 5 + value
cfg_parity  input  2  0 none, 1 even, 2 odd, 3 reserved (= none)
cfg_stop2  input  1  1 = two stop bits
tx_data  input  8  byte to send; bits above data-bit count ignored
tx_valid  input  1  producer has a byte
tx_ready  output  1  FIFO not full; transfer on clk edge with tx_valid & tx_ready
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress or FIFO non-empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values, while rst=0 at a clk edge: tx=1, tx_ready=1, busy=0, fifo_level=0, FSM=IDLE, FIFO empty, all counters 0. Reset mid-frame aborts the frame immediately; tx returns to 1 on that edge, FIFO contents discarded.
- FIFO:
  - push on tx_valid & tx_ready
  - pop when FSM is IDLE and FIFO is non-empty
  - tx_ready = !full (combinational from registered count)
  - push and pop in the same cycle: level unchanged, data order preserved
  - pointers wrap modulo FIFO_DEPTH
- Config latch: on the pop edge, latch the popped byte, baud_div (0→1), data-bit count, parity mode and stop count. Input changes mid-frame do not affect the frame in progress.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on pop.
  - START → DATA after 1 bit period.
  - DATA → PARITY after last data bit if parity enabled, else → STOP.
  - PARITY → STOP after 1 bit period.
  - STOP → IDLE after 1 or 2 bit periods.
  - STOP always passes through IDLE, which costs one cycle at tx=1 before the next pop.
- Bit period: cycle counter runs 0..div-1 and ends the bit at div-1. Bit counter counts data bits, LSB first, and stop bits.
- tx is registered and driven from the next state:
  - START: 0
  - DATA: latched_byte[bit_cnt]
  - PARITY: XOR of the used data bits for even; inverted for odd
  - STOP/IDLE: 1
- Latency: byte accepted at edge E with FIFO empty and FSM idle → pop at edge E+1, tx=0 after edge E+1. Start bit lasts exactly div cycles.
- Frame length: div × (1 + N + P + S) cycles, plus 1 idle cycle between back-to-back frames.
- busy = (state != IDLE) | (fifo_level != 0).
- fifo_level arithmetic is unsigned. It never exceeds FIFO_DEPTH and never underflows.

Decomposition:
- Package uart_pkg:
  - enum parity_e {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD}
  - enum tx_state_e {IDLE, START, DATA, PARITY, STOP}
  - constant DATA_BITS_BASE=5
  - function parity_bit(data, nbits, mode)
- Sub-module uart_sync_fifo, parameterised by width and depth, with push/pop/full/empty/level.
- The FSM, baud counter and shifter stay in uart_tx_fifo.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with tx_valid=1 → tx=1, tx_ready=1, busy=0, fifo_level=0, no push. Release: push on first edge, tx=0 one edge later.
2. 8N1, div=4, byte 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. busy falls after 40 cycles plus the pop cycle.
3. 7E2, div=3, byte 0xD3 → data bits 1,1,0,0,1,0,1, parity 0, two stop bits; 33-cycle frame; bit 7 of the byte ignored.
4. 5O1, div=0 (treated as 1), byte 0x1F → data 1,1,1,1,1, parity 0, stop 1; 8 cycles per frame.
5. Burst: push 6 bytes back-to-back with FIFO_DEPTH=4, div=2:
   - tx_ready drops when fifo_level=4
   - resumes after each pop
   - all 6 bytes appear in order
   - exactly one idle cycle between frames
   - also change baud_div/cfg mid-frame → current frame unaffected, next frame uses the new values.
6. Reset mid-frame: assert rst=0 during DATA bit 3 → tx=1 on the next edge, FIFO empty, and the first frame after release is clean.
